// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - IF-stage fetch sequencer: PC next/enable, imem handshake, IF/ID load
//
// Purpose: owns the fetch address, issues instruction-memory requests,
// loads the IF/ID register, and applies hazard stalls and branch/jump redirects.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   stall                           hazard unit: hold IF/ID and PC
//   branch_taken/branch_target      taken branch resolved in ID
//   jump/jump_target                jump decoded in ID
//   imem_req/imem_addr              request valid / registered request address
//   imem_ready/imem_rdata           response valid this cycle / fetched word
//   pc_next/pc_enable               value and write-enable for the PC register
//   ifid_valid/ifid_instr/ifid_pc4  IF/ID pipeline register
//   misalign                        sticky: a redirect target was not word aligned
module fetch_sequencer #(
  parameter int               ADDR_W       = 32,
  parameter int               INSTR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               pc_enable,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc4,
  output logic               misalign
);

  localparam logic [1:0] S_BOOT    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]         state_q,       state_d;
  logic [ADDR_W-1:0]  pc_cur_q,      pc_cur_d;
  logic [ADDR_W-1:0]  addr_q,        addr_d;
  logic               skid_valid_q,  skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q,  skid_instr_d;
  logic [ADDR_W-1:0]  skid_pc4_q,    skid_pc4_d;
  logic               ifid_valid_q,  ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q,  ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc4_q,    ifid_pc4_d;
  logic               misalign_q,    misalign_d;

  logic              req_c;
  logic              accept_c;
  logic              redirect_c;
  logic [ADDR_W-1:0] target_c;

  always_comb begin
    state_d      = state_q;
    pc_cur_d     = pc_cur_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    misalign_d   = misalign_q;

    redirect_c = branch_taken | jump;
    target_c   = branch_taken ? branch_target : jump_target;

    // A full skid under stall has nowhere to put another word, so fetch pauses.
    case (state_q)
      S_FETCH:           req_c = ~(stall & skid_valid_q);
      S_WAIT, S_DISCARD: req_c = 1'b1;
      default:           req_c = 1'b0;
    endcase
    accept_c = req_c & imem_ready & ((state_q == S_FETCH) | (state_q == S_WAIT));

    case (state_q)
      S_BOOT:    state_d = S_FETCH;
      S_FETCH:   if (!accept_c && req_c) state_d = S_WAIT;
      S_WAIT:    if (imem_ready) state_d = S_FETCH;
      default:   if (imem_ready) state_d = S_FETCH;
    endcase
    if (accept_c) pc_cur_d = pc_cur_q + ADDR_W'(4);

    if (state_q != S_BOOT) begin
      if (redirect_c) begin
        // Redirect wins over stall; any word accepted this cycle is wrong-path.
        pc_cur_d     = {target_c[ADDR_W-1:2], 2'b00};
        misalign_d   = misalign_q | (target_c[1:0] != 2'b00);
        ifid_valid_d = 1'b0;
        ifid_instr_d = '0;
        ifid_pc4_d   = '0;
        skid_valid_d = 1'b0;
        // An outstanding request must still be completed at its old address.
        state_d = (((state_q == S_WAIT) || (state_q == S_DISCARD)) && !imem_ready)
                  ? S_DISCARD : S_FETCH;
      end else if (stall) begin
        if (accept_c) begin
          skid_valid_d = 1'b1;
          skid_instr_d = imem_rdata;
          skid_pc4_d   = addr_q + ADDR_W'(4);
        end
      end else begin
        // Skid is older than any word arriving now, so it goes to IF/ID first.
        if (skid_valid_q) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = skid_instr_q;
          ifid_pc4_d   = skid_pc4_q;
          skid_valid_d = accept_c;
          if (accept_c) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = addr_q + ADDR_W'(4);
          end
        end else if (accept_c) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = imem_rdata;
          ifid_pc4_d   = addr_q + ADDR_W'(4);
        end else begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = '0;
          ifid_pc4_d   = '0;
        end
      end
    end

    addr_d = (state_d == S_DISCARD) ? addr_q : pc_cur_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_cur_q     <= RESET_VECTOR;
      addr_q       <= RESET_VECTOR;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_cur_q     <= pc_cur_d;
      addr_q       <= addr_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req   = req_c;
  assign imem_addr  = addr_q;
  // BOOT also holds during reset; gate so the PC register is not written then.
  assign pc_enable  = rst_n & ((state_q == S_BOOT) | (pc_cur_d != pc_cur_q));
  assign pc_next    = (state_q == S_BOOT) ? RESET_VECTOR : pc_cur_d;
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, pc_enable, ifid_valid, misalign;
  logic [31:0] imem_addr, imem_rdata, pc_next, ifid_instr, ifid_pc4;

  always #5 clk = ~clk;

  // Memory returns its own address as the instruction word.
  assign imem_rdata = imem_addr;

  fetch_sequencer #(.ADDR_W(32), .INSTR_W(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc_next(pc_next), .pc_enable(pc_enable),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .misalign(misalign)
  );

  typedef struct {
    logic s; logic b; logic [31:0] bt; logic j; logic [31:0] jt; logic r;
    logic e_req; logic [31:0] e_addr; logic e_pen; logic [31:0] e_pn;
    logic e_v; logic [31:0] e_i; logic [31:0] e_p4; logic e_m;
  } vec_t;

  typedef struct {
    logic v; logic [31:0] i; logic [31:0] p4; logic m;
  } ifid_t;

  vec_t  vecs[$];
  ifid_t sb[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic r,
                              input logic req, input logic [31:0] a, input logic pen,
                              input logic [31:0] pn, input logic v, input logic [31:0] i,
                              input logic [31:0] p4, input logic m);
    vec_t t;
    t.s = s; t.b = b; t.bt = bt; t.j = j; t.jt = jt; t.r = r;
    t.e_req = req; t.e_addr = a; t.e_pen = pen; t.e_pn = pn;
    t.e_v = v; t.e_i = i; t.e_p4 = p4; t.e_m = m;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " imem_req"},   {31'b0, imem_req},   32'h0);
    chk({tag, " imem_addr"},  imem_addr,           32'h0);
    chk({tag, " pc_enable"},  {31'b0, pc_enable},  32'h0);
    chk({tag, " pc_next"},    pc_next,             32'h0);
    chk({tag, " ifid_valid"}, {31'b0, ifid_valid}, 32'h0);
    chk({tag, " ifid_instr"}, ifid_instr,          32'h0);
    chk({tag, " ifid_pc4"},   ifid_pc4,            32'h0);
    chk({tag, " misalign"},   {31'b0, misalign},   32'h0);
  endtask

  initial begin
    ifid_t e, got;
    // stall br bt j jt rdy | req addr pen pc_next | next IF/ID: v instr pc4 misalign
    vecs.push_back(mk(0,0,0,0,0,1, 0,32'h00,1,32'h00, 0,32'h00,32'h00,0)); // BOOT
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h00,1,32'h04, 1,32'h00,32'h04,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h04,1,32'h08, 1,32'h04,32'h08,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h08,1,32'h0C, 1,32'h08,32'h0C,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h0C,1,32'h10, 1,32'h0C,32'h10,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h10,1,32'h14, 1,32'h10,32'h14,0));
    vecs.push_back(mk(1,0,0,0,0,1, 1,32'h14,1,32'h18, 1,32'h10,32'h14,0)); // 0x14 -> skid
    vecs.push_back(mk(1,0,0,0,0,1, 0,32'h18,0,32'h18, 1,32'h10,32'h14,0));
    vecs.push_back(mk(1,0,0,0,0,1, 0,32'h18,0,32'h18, 1,32'h10,32'h14,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h18,1,32'h1C, 1,32'h14,32'h18,0)); // skid drains
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h1C,1,32'h20, 1,32'h18,32'h1C,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h20,0,32'h20, 1,32'h1C,32'h20,0)); // ready low x4
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h20,0,32'h20, 0,32'h00,32'h00,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h20,0,32'h20, 0,32'h00,32'h00,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h20,0,32'h20, 0,32'h00,32'h00,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h20,1,32'h24, 1,32'h20,32'h24,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h24,1,32'h28, 1,32'h24,32'h28,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h28,1,32'h2C, 1,32'h28,32'h2C,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h2C,1,32'h30, 1,32'h2C,32'h30,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h30,1,32'h34, 1,32'h30,32'h34,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h34,1,32'h38, 1,32'h34,32'h38,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h38,1,32'h3C, 1,32'h38,32'h3C,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h3C,1,32'h40, 1,32'h3C,32'h40,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h40,0,32'h40, 0,32'h00,32'h00,0)); // WAIT at 0x40
    vecs.push_back(mk(0,1,32'h100,1,32'h300,0, 1,32'h40,1,32'h100, 0,32'h00,32'h00,0));
    vecs.push_back(mk(0,0,0,0,0,0, 1,32'h40,0,32'h100, 0,32'h00,32'h00,0)); // DISCARD
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h40,0,32'h100, 0,32'h00,32'h00,0)); // drop 0x40
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h100,1,32'h104, 1,32'h100,32'h104,0));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0,1, 1,32'h104,1,32'hFFFF_FFFC, 0,32'h00,32'h00,0));
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'hFFFF_FFFC,1,32'h00, 1,32'hFFFF_FFFC,32'h00,0)); // wrap
    vecs.push_back(mk(1,0,0,1,32'h203,1, 1,32'h00,1,32'h200, 0,32'h00,32'h00,1)); // stall+jump
    vecs.push_back(mk(0,0,0,0,0,1, 1,32'h200,1,32'h204, 1,32'h200,32'h204,1));
    vecs.push_back(mk(1,0,0,0,0,0, 1,32'h204,0,32'h204, 1,32'h200,32'h204,1)); // -> WAIT

    rst_n = 1'b0; stall = 0; branch_taken = 0; jump = 0; imem_ready = 1;
    branch_target = 0; jump_target = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      stall = vecs[k].s; branch_taken = vecs[k].b; branch_target = vecs[k].bt;
      jump = vecs[k].j; jump_target = vecs[k].jt; imem_ready = vecs[k].r;
      @(negedge clk);
      chk($sformatf("v%0d imem_req", k),  {31'b0, imem_req},  {31'b0, vecs[k].e_req});
      chk($sformatf("v%0d imem_addr", k), imem_addr,          vecs[k].e_addr);
      chk($sformatf("v%0d pc_enable", k), {31'b0, pc_enable}, {31'b0, vecs[k].e_pen});
      chk($sformatf("v%0d pc_next", k),   pc_next,            vecs[k].e_pn);
      e.v = vecs[k].e_v; e.i = vecs[k].e_i; e.p4 = vecs[k].e_p4; e.m = vecs[k].e_m;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk($sformatf("v%0d ifid_valid", k), {31'b0, ifid_valid}, {31'b0, got.v});
      chk($sformatf("v%0d ifid_instr", k), ifid_instr,          got.i);
      chk($sformatf("v%0d ifid_pc4", k),   ifid_pc4,            got.p4);
      chk($sformatf("v%0d misalign", k),   {31'b0, misalign},   {31'b0, got.m});
    end

    // Reset asserted mid-WAIT: outputs return to reset values without a clock edge.
    stall = 0; imem_ready = 0;
    #2 rst_n = 1'b0;
    #1 chk_reset("async reset");
    imem_ready = 1;
    @(posedge clk);
    #1 chk_reset("late ready");
    rst_n = 1'b1;
    @(negedge clk);
    chk("reboot imem_req",  {31'b0, imem_req},  32'h0);
    chk("reboot pc_enable", {31'b0, pc_enable}, 32'h1);
    chk("reboot pc_next",   pc_next,            32'h0);
    @(posedge clk);
    #1;
    chk("refetch imem_req",  {31'b0, imem_req}, 32'h1);
    chk("refetch imem_addr", imem_addr,         32'h0);
    chk("refetch pc_next",   pc_next,           32'h4);
    @(posedge clk);
    #1;
    chk("refetch ifid_valid", {31'b0, ifid_valid}, 32'h1);
    chk("refetch ifid_instr", ifid_instr,          32'h0);
    chk("refetch ifid_pc4",   ifid_pc4,            32'h4);
    chk("refetch misalign",   {31'b0, misalign},   32'h0);
    chk("refetch imem_addr2", imem_addr,           32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the program-counter register of the 5-stage MIPS pipeline: computes its next address and write-enable.
- Issues instruction-memory requests with a ready handshake and loads the IF/ID pipeline register.
- Applies hazard stalls and branch/jump redirects (with flush).
- Sits between the hazard/branch logic in ID and the PC register plus instruction memory.

Parameters:
- ADDR_W, 32, address and PC width.
- INSTR_W, 32, instruction width.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold IF/ID and PC.
- branch_taken  in  1  taken branch resolved in ID.
- branch_target  in  ADDR_W  branch destination.
- jump  in  1  jump decoded in ID.
- jump_target  in  ADDR_W  jump destination.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request address.
- imem_ready  in  1  imem_rdata valid for current imem_addr this cycle.
- imem_rdata  in  INSTR_W  fetched word.
- pc_next  out  ADDR_W  value to load into PC register.
- pc_enable  out  1  PC register write-enable.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  INSTR_W  IF/ID instruction (0 = NOP when invalid).
- ifid_pc4  out  ADDR_W  fetch address + 4.
- misalign  out  1  sticky: a redirect target had addr[1:0] != 0.

Behaviour:
- Reset (async, rst_n low), effective immediately:
  - state=BOOT, pc_cur=RESET_VECTOR, skid empty.
  - imem_req=0, imem_addr=RESET_VECTOR, pc_enable=0, pc_next=RESET_VECTOR.
  - ifid_valid=0, ifid_instr=0, ifid_pc4=0, misalign=0.
  - Reset mid-request abandons the request; a late imem_ready is ignored.
- States: BOOT, FETCH, WAIT, DISCARD.
- BOOT:
  - First rising edge after rst_n high -> FETCH.
  - pc_enable=1, pc_next=RESET_VECTOR for that cycle.
- imem_req/imem_addr:
  - imem_req=1 in WAIT and DISCARD.
  - imem_req=1 in FETCH unless stall=1 and skid full.
  - imem_addr is registered = pc_cur and stable while imem_req=1 and imem_ready=0.
- FETCH with imem_req=1:
  - imem_ready=1: word accepted; pc_cur <= pc_cur+4; stay in FETCH.
  - imem_ready=0: -> WAIT.
  - Single-cycle memory gives 1 instruction/cycle; response-to-IF/ID latency is 1 clock.
- WAIT: hold address; on imem_ready accept word and advance pc_cur -> FETCH.
- Accepted word, stall=0: IF/ID <= {valid=1, rdata, imem_addr+4}.
- Accepted word, stall=1:
  - Word goes into the 1-entry skid register; IF/ID held.
  - No further request is issued until the skid drains.
  - Skid drains into IF/ID on the first cycle with stall=0, before any new word; a word accepted that same cycle goes to the skid.
- Redirect: target = branch_taken ? branch_target : (jump ? jump_target : none). Branch beats jump.
- On redirect (overrides stall):
  - pc_cur <= {target[ADDR_W-1:2],2'b00}; misalign set if target[1:0]!=0.
  - IF/ID flushed to valid=0, instr=0, pc4=0; skid cleared.
  - If in WAIT with imem_ready=0 -> DISCARD. DISCARD keeps the old address until imem_ready, drops that word, then -> FETCH at the new pc_cur.
  - Otherwise -> FETCH; the next request uses the target.
- pc_enable=1 exactly on cycles where pc_cur changes; pc_next = the new value.
  - pc_next/pc_enable are combinational and settle before the falling edge, where the PC register samples.
- Arithmetic: pc_cur+4 modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0 with no flag.
- Redirect and stall in the same cycle: redirect wins, stall ignored for that cycle.

Test Plan:
- Reset release, imem_ready tied 1, rdata=addr -> imem_addr 0,4,8,... one per cycle; ifid_instr=0,4,8 with one-cycle lag; ifid_pc4=4,8,12; pc_enable=1 every cycle.
- stall=1 for 3 cycles while fetching 0x10 -> IF/ID holds; 0x14 enters skid; imem_req=0; on release IF/ID=0x14 next cycle, then 0x18 with no loss or duplicate.
- imem_ready low 4 cycles at 0x20 -> imem_addr stays 0x20; state WAIT; pc_enable=0 until ready.
- branch_taken with branch_target=0x100 during WAIT at 0x40 -> IF/ID flushed; 0x40 word discarded on ready; next request 0x100; jump asserted simultaneously is ignored.
- jump_target=0x203 -> fetch 0x200; misalign=1 and sticky until rst_n low.
- pc_cur=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000; misalign stays 0.
- rst_n low during WAIT -> all outputs at reset values immediately; late imem_ready ignored; fetch restarts at RESET_VECTOR.
